// File: rtl/bsg_manycore_eva_to_npa.sv
// Translates an effective virtual byte address into a mesh coordinate plus endpoint word address.
// Latency: 0 cycles (purely combinational, no state); no flow control, so no backpressure.
module bsg_manycore_eva_to_npa #(
    parameter int data_width_p                 = 32,
    parameter int addr_width_p                 = 28,
    parameter int x_cord_width_p               = 6,
    parameter int y_cord_width_p               = 6,
    parameter int num_tiles_x_p                = 4,
    parameter int num_tiles_y_p                = 4,
    parameter int vcache_block_size_in_words_p = 8,
    parameter int vcache_size_p                = 1024,
    parameter int vcache_sets_p                = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [data_width_p-1:0]   eva_i,
    input  logic                      dram_enable_i,
    input  logic [x_cord_width_p-1:0] tgo_x_i,
    input  logic [y_cord_width_p-1:0] tgo_y_i,
    input  logic [x_cord_width_p-1:0] tg_dim_x_width_i,
    input  logic [y_cord_width_p-1:0] tg_dim_y_width_i,
    output logic [x_cord_width_p-1:0] x_cord_o,
    output logic [y_cord_width_p-1:0] y_cord_o,
    output logic [addr_width_p-1:0]   epa_o,
    output logic                      is_invalid_addr_o
);

    localparam int LGX = $clog2(num_tiles_x_p);
    localparam int W   = $clog2(vcache_block_size_in_words_p);
    localparam int VAW = $clog2(vcache_size_p);
    // Everything is computed in a wide staging width so field selects and
    // truncation/extension to the port widths never depend on parameter values.
    localparam int SW  = 64;

    localparam int              NODRAM_LSB  = 2 + VAW + LGX;
    localparam logic [SW-1:0]   NODRAM_MASK = ((SW'(1) << 31) - SW'(1))
                                            & ~((SW'(1) << NODRAM_LSB) - SW'(1));
    localparam logic [SW-1:0]   DRAM_Y      = SW'(num_tiles_y_p + 1);

    logic [SW-1:0] w_eva;
    logic [SW-1:0] w_tg_mask_x;
    logic [SW-1:0] w_tg_mask_y;
    logic [SW-1:0] w_x;
    logic [SW-1:0] w_y;
    logic [SW-1:0] w_epa;
    logic          w_invalid;
    logic          w_unused;

    assign w_eva       = SW'(eva_i);
    assign w_tg_mask_x = (SW'(1) << tg_dim_x_width_i) - SW'(1);
    assign w_tg_mask_y = (SW'(1) << tg_dim_y_width_i) - SW'(1);

    // Default is the invalid encoding, so every unmatched path yields all-zero outputs.
    always_comb begin
        w_x       = '0;
        w_y       = '0;
        w_epa     = '0;
        w_invalid = 1'b1;
        if (w_eva[31]) begin
            if (dram_enable_i) begin
                w_x       = SW'(w_eva[2+W +: LGX]);
                w_y       = w_eva[2+W+LGX] ? DRAM_Y : '0;
                w_epa     = SW'({w_eva[3+W+LGX +: VAW-W], w_eva[2 +: W]});
                w_invalid = 1'b0;
            end else if ((w_eva & NODRAM_MASK) == '0) begin
                w_x       = SW'(w_eva[2+VAW +: LGX]);
                w_y       = DRAM_Y;
                w_epa     = SW'(w_eva[2 +: VAW]);
                w_invalid = 1'b0;
            end
        end else if (w_eva[30]) begin
            w_x       = SW'(w_eva[23:18]);
            w_y       = SW'(w_eva[29:24]);
            w_epa     = SW'(w_eva[17:2]);
            w_invalid = 1'b0;
        end else if (w_eva[29]) begin
            // Sums wrap naturally when the low coordinate bits are taken below.
            w_x       = SW'(tgo_x_i) + (SW'(w_eva[23:18]) & w_tg_mask_x);
            w_y       = SW'(tgo_y_i) + (SW'(w_eva[28:24]) & w_tg_mask_y);
            w_epa     = SW'(w_eva[17:2]);
            w_invalid = 1'b0;
        end
    end

    assign x_cord_o          = w_x[x_cord_width_p-1:0];
    assign y_cord_o          = w_y[y_cord_width_p-1:0];
    assign epa_o             = w_epa[addr_width_p-1:0];
    assign is_invalid_addr_o = w_invalid;

    // Clock and reset exist only for port compatibility; they never reach the outputs.
    assign w_unused = ^{clk_i, reset_i, w_eva,
                        w_x[SW-1:x_cord_width_p], w_y[SW-1:y_cord_width_p],
                        w_epa[SW-1:addr_width_p]};

endmodule

// File: tb/tb_bsg_manycore_eva_to_npa.sv
// Table-driven bench for the EVA-to-NPA translator with a queue scoreboard.
module tb_bsg_manycore_eva_to_npa;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] eva_i;
    logic        dram_enable_i;
    logic [5:0]  tgo_x_i, tgo_y_i, tg_dim_x_width_i, tg_dim_y_width_i;
    logic [5:0]  x_cord_o, y_cord_o;
    logic [27:0] epa_o;
    logic        is_invalid_addr_o;

    always #5 clk_i = ~clk_i;

    bsg_manycore_eva_to_npa dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .eva_i            (eva_i),
        .dram_enable_i    (dram_enable_i),
        .tgo_x_i          (tgo_x_i),
        .tgo_y_i          (tgo_y_i),
        .tg_dim_x_width_i (tg_dim_x_width_i),
        .tg_dim_y_width_i (tg_dim_y_width_i),
        .x_cord_o         (x_cord_o),
        .y_cord_o         (y_cord_o),
        .epa_o            (epa_o),
        .is_invalid_addr_o(is_invalid_addr_o)
    );

    typedef struct {
        string       name;
        logic [31:0] eva;
        logic        dram;
        logic [5:0]  tgx, tgy, dimx, dimy;
        logic [5:0]  ex, ey;
        logic [27:0] eepa;
        logic        einv;
    } vec_t;

    typedef struct {
        string       name;
        logic [5:0]  ex, ey;
        logic [27:0] eepa;
        logic        einv;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(string name, logic [31:0] eva, logic dram,
                                logic [5:0] tgx, logic [5:0] tgy, logic [5:0] dimx, logic [5:0] dimy,
                                logic [5:0] ex, logic [5:0] ey, logic [27:0] eepa, logic einv);
        vec_t v;
        v.name = name; v.eva = eva; v.dram = dram;
        v.tgx = tgx; v.tgy = tgy; v.dimx = dimx; v.dimy = dimy;
        v.ex = ex; v.ey = ey; v.eepa = eepa; v.einv = einv;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        exp_t e;
        eva_i            = v.eva;
        dram_enable_i    = v.dram;
        tgo_x_i          = v.tgx;
        tgo_y_i          = v.tgy;
        tg_dim_x_width_i = v.dimx;
        tg_dim_y_width_i = v.dimy;
        e.name = v.name; e.ex = v.ex; e.ey = v.ey; e.eepa = v.eepa; e.einv = v.einv;
        sb.push_back(e);
    endtask

    task automatic compare_front(string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got x=%0d y=%0d epa=0x%0h inv=%0b expected a queued entry",
                     tag, x_cord_o, y_cord_o, epa_o, is_invalid_addr_o);
        end else begin
            e = sb[0];
            check({tag, ".", e.name, ".x"},   32'(x_cord_o),          32'(e.ex));
            check({tag, ".", e.name, ".y"},   32'(y_cord_o),          32'(e.ey));
            check({tag, ".", e.name, ".epa"}, 32'(epa_o),             32'(e.eepa));
            check({tag, ".", e.name, ".inv"}, 32'(is_invalid_addr_o), 32'(e.einv));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   name            eva           dr tgx tgy dx dy  ex  ey  epa        inv
        add("global",       32'h43080040, 1,  9,  9, 3, 3,  2,  3, 28'h10,    0);
        add("tg_unmasked",  32'h21040008, 0,  1,  1, 1, 1,  2,  2, 28'h2,     0);
        add("tg_masked",    32'h210C0008, 0,  1,  1, 1, 1,  2,  2, 28'h2,     0);
        add("dram_striped", 32'h800001D4, 1,  0,  0, 0, 0,  2,  5, 28'hD,     0);
        add("nodram_ok",    32'h80003010, 0,  0,  0, 0, 0,  3,  5, 28'h4,     0);
        add("nodram_oor",   32'h80004000, 0,  0,  0, 0, 0,  0,  0, 28'h0,     1);
        add("local",        32'h00001000, 1,  1,  1, 1, 1,  0,  0, 28'h0,     1);
        add("dram_north",   32'h80000124, 1,  0,  0, 0, 0,  1,  0, 28'h9,     0);
        add("dram_all1",    32'hFFFFFFFF, 1,  0,  0, 0, 0,  3,  5, 28'h3FF,   0);
        add("nodram_max",   32'h80003FFC, 0,  0,  0, 0, 0,  3,  5, 28'h3FF,   0);
        add("nodram_b30",   32'hC0000000, 0,  0,  0, 0, 0,  0,  0, 28'h0,     1);
        add("global_all1",  32'h7FFFFFFF, 0,  1,  2, 0, 0, 63, 63, 28'hFFFF,  0);
        add("tg_wrap",      32'h21040008, 0, 63, 63, 2, 2,  0,  0, 28'h2,     0);
        add("tg_dim0",      32'h3FFC0004, 0,  5,  7, 0, 0,  5,  7, 28'h1,     0);
        add("tg_full",      32'h3FFC0000, 0,  0,  0, 6, 5, 63, 31, 28'h0,     0);
        add("local_hi",     32'h1FFFFFFF, 1,  3,  3, 2, 2,  0,  0, 28'h0,     1);

        // Outputs while reset is asserted must already follow the inputs.
        reset_i = 1'b1;
        drive(vecs[0]);
        @(posedge clk_i); #1;
        compare_front("reset");
        void'(sb.pop_front());
        reset_i = 1'b0;

        // Main table: sampled within the same half cycle, showing zero latency.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            drive(vecs[i]);
            #1;
            compare_front("table");
            void'(sb.pop_front());
        end

        // Reset toggling while a vector is held must never disturb the outputs.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            drive(vecs[i]);
            for (int c = 0; c < 4; c++) begin
                reset_i = ~reset_i;
                @(posedge clk_i); #1;
                compare_front("rst_toggle");
            end
            void'(sb.pop_front());
        end
        reset_i = 1'b0;

        // Back-to-back input changes between clock edges.
        @(posedge clk_i); #2;
        drive(vecs[3]); #1;
        compare_front("midcycle");
        void'(sb.pop_front());
        drive(vecs[5]); #1;
        compare_front("midcycle");
        void'(sb.pop_front());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
